// File: rtl/score_arbiter_pkg.sv
// rtl/score_arbiter_pkg.sv - shared types and constants for the score arbiter
package score_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_TARGETS_DEF = 3;

  localparam logic [10:0] SCORE_MAX = 11'd2047;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/score_arbiter_bcd_counter2.sv
// rtl/score_arbiter_bcd_counter2.sv - two-digit saturating BCD incrementer
module bcd_counter2
  import score_arbiter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [3:0] o_ones,
  output logic [3:0] o_tens
);

  bcd_digit_t r_ones;
  bcd_digit_t r_tens;
  logic       w_at_max;

  assign w_at_max = (r_ones == BCD_NINE) && (r_tens == BCD_NINE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_clear) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_inc && !w_at_max) begin
      if (r_ones == BCD_NINE) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_ones = r_ones;
  assign o_tens = r_tens;

endmodule

// File: rtl/score_arbiter.sv
// rtl/score_arbiter.sv - once-per-game target capture with round-robin scoring grants
module score_arbiter
  import score_arbiter_pkg::*;
#(
  parameter int NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int ID_W        = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [NUM_TARGETS-1:0] hit,
  output logic [NUM_TARGETS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   score_pulse,
  output logic [10:0]            score,
  output logic [3:0]             bcd_ones,
  output logic [3:0]             bcd_tens,
  output logic [NUM_TARGETS-1:0] pending,
  output logic                   all_scored
);

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_TARGETS - 1);

  state_t                 r_state;
  logic [NUM_TARGETS-1:0] r_armed;
  logic [NUM_TARGETS-1:0] r_pending;
  logic [NUM_TARGETS-1:0] r_grant;
  logic [ID_W-1:0]        r_grant_id;
  logic [ID_W-1:0]        r_last_grant;
  logic                   r_score_pulse;
  logic [10:0]            r_score;
  logic                   r_all_scored;

  logic [NUM_TARGETS-1:0] w_capture;
  logic [NUM_TARGETS-1:0] w_grant_vec;
  logic [NUM_TARGETS-1:0] w_pending_nxt;
  logic [NUM_TARGETS-1:0] w_armed_nxt;
  logic [ID_W-1:0]        w_grant_idx;
  logic                   w_found;
  int                     w_cand;

  // Search starts one past the last winner so every pending target is reached within NUM_TARGETS grants.
  always_comb begin
    w_capture = hit & r_armed & ~r_pending & {NUM_TARGETS{enable}};
    if (r_state == DONE) w_capture = '0;
    w_grant_vec = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = 0;
    if (enable) begin
      for (int off = 1; off <= NUM_TARGETS; off++) begin
        w_cand = (int'(r_last_grant) + off) % NUM_TARGETS;
        if (!w_found && r_pending[w_cand]) begin
          w_found             = 1'b1;
          w_grant_idx         = ID_W'(w_cand);
          w_grant_vec[w_cand] = 1'b1;
        end
      end
    end
    w_pending_nxt = (r_pending & ~w_grant_vec) | w_capture;
    w_armed_nxt   = r_armed & ~w_capture;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_armed       <= '1;
      r_pending     <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_last_grant  <= LAST_INIT;
      r_score_pulse <= 1'b0;
      r_score       <= '0;
      r_all_scored  <= 1'b0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_armed       <= '1;
      r_pending     <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_last_grant  <= LAST_INIT;
      r_score_pulse <= 1'b0;
      r_score       <= '0;
      r_all_scored  <= 1'b0;
    end else begin
      r_armed       <= w_armed_nxt;
      r_pending     <= w_pending_nxt;
      r_grant       <= w_grant_vec;
      r_score_pulse <= w_found;
      if (w_found) begin
        r_grant_id   <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        if (r_score != SCORE_MAX) r_score <= r_score + 11'd1;
      end
      case (r_state)
        IDLE: begin
          if (|w_capture) r_state <= SERVE;
        end
        SERVE: begin
          if (w_pending_nxt == '0) begin
            if (w_armed_nxt == '0) begin
              r_state      <= DONE;
              r_all_scored <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state      <= IDLE;
          r_all_scored <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter2 u_bcd (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_clear (clear),
    .i_inc   (w_found),
    .o_ones  (bcd_ones),
    .o_tens  (bcd_tens)
  );

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign score_pulse = r_score_pulse;
  assign score       = r_score;
  assign pending     = r_pending;
  assign all_scored  = r_all_scored;

endmodule

// File: tb/tb_score_arbiter.sv
// tb/tb_score_arbiter.sv - scoreboard bench for score_arbiter and bcd_counter2
module tb_score_arbiter;
  import score_arbiter_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int id;
    int score;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic        clear_a = 1'b0, enable_a = 1'b1;
  logic [2:0]  hit_a = '0;
  logic [2:0]  grant_a, grant_id_a, pending_a;
  logic        score_pulse_a, all_a;
  logic [10:0] score_a;
  logic [3:0]  ones_a, tens_a;

  logic        clear_b = 1'b0, enable_b = 1'b1;
  logic [7:0]  hit_b = '0;
  logic [7:0]  grant_b, pending_b;
  logic [2:0]  grant_id_b;
  logic        score_pulse_b, all_b;
  logic [10:0] score_b;
  logic [3:0]  ones_b, tens_b;

  logic        bc_clear = 1'b0, bc_inc = 1'b0;
  logic [3:0]  bc_ones, bc_tens;

  score_arbiter #(.NUM_TARGETS(3), .ID_W(3)) dut_a (
    .Clk(Clk), .Reset(Reset), .clear(clear_a), .enable(enable_a), .hit(hit_a),
    .grant(grant_a), .grant_id(grant_id_a), .score_pulse(score_pulse_a),
    .score(score_a), .bcd_ones(ones_a), .bcd_tens(tens_a),
    .pending(pending_a), .all_scored(all_a)
  );

  score_arbiter #(.NUM_TARGETS(8), .ID_W(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .clear(clear_b), .enable(enable_b), .hit(hit_b),
    .grant(grant_b), .grant_id(grant_id_b), .score_pulse(score_pulse_b),
    .score(score_b), .bcd_ones(ones_b), .bcd_tens(tens_b),
    .pending(pending_b), .all_scored(all_b)
  );

  bcd_counter2 dut_bcd (
    .Clk(Clk), .Reset(Reset), .i_clear(bc_clear), .i_inc(bc_inc),
    .o_ones(bc_ones), .o_tens(bc_tens)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bcd_of(input int s);
    return ((s / 10) << 4) | (s % 10);
  endfunction

  always @(negedge Clk) begin : mon_a
    exp_t e;
    if (!Reset && score_pulse_a) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse_a: got id %0d expected no pulse", grant_id_a);
      end else begin
        e = qa.pop_front();
        chk("grant_id_a", int'(grant_id_a), e.id);
        chk("score_a", int'(score_a), e.score);
        chk("grant_a", int'(grant_a), 1 << e.id);
        chk("bcd_a", int'({tens_a, ones_a}), bcd_of(e.score));
      end
    end
  end

  always @(negedge Clk) begin : mon_b
    exp_t e;
    if (!Reset && score_pulse_b) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse_b: got id %0d expected no pulse", grant_id_b);
      end else begin
        e = qb.pop_front();
        chk("grant_id_b", int'(grant_id_b), e.id);
        chk("score_b", int'(score_b), e.score);
        chk("grant_b", int'(grant_b), 1 << e.id);
        chk("bcd_b", int'({tens_b, ones_b}), bcd_of(e.score));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear_pulse_a;
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int t = 0;
    while (qa.size() != 0 && t < 40) begin
      @(negedge Clk);
      t++;
    end
    tick(1);
    chk(name, qa.size(), 0);
  endtask

  task automatic drain_b(input string name);
    int t = 0;
    while (qb.size() != 0 && t < 40) begin
      @(negedge Clk);
      t++;
    end
    tick(1);
    chk(name, qb.size(), 0);
  endtask

  task automatic bcd_incs(input int n);
    bc_inc = 1'b1;
    tick(n);
    bc_inc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_grant", int'(grant_a), 0);
    chk("rst_grant_id", int'(grant_id_a), 0);
    chk("rst_pulse", int'(score_pulse_a), 0);
    chk("rst_score", int'(score_a), 0);
    chk("rst_bcd", int'({tens_a, ones_a}), 0);
    chk("rst_pending", int'(pending_a), 0);
    chk("rst_all", int'(all_a), 0);
    Reset = 1'b0;
    tick(1);

    // single hit, two-edge latency
    clear_pulse_a();
    hit_a = 3'b010;
    qa.push_back('{1, 1});
    tick(1);
    hit_a = '0;
    chk("t1_pending_captured", int'(pending_a), 2);
    chk("t1_no_early_pulse", int'(score_pulse_a), 0);
    tick(1);
    chk("t1_pulse_latency", int'(score_pulse_a), 1);
    drain_a("t1_drain");
    tick(3);
    chk("t1_score", int'(score_a), 1);
    chk("t1_pending", int'(pending_a), 0);
    chk("t1_all", int'(all_a), 0);
    chk("t1_state", int'(dut_a.r_state), int'(IDLE));

    // simultaneous hits served on consecutive cycles, then game done
    clear_pulse_a();
    hit_a = 3'b111;
    qa.push_back('{0, 1});
    qa.push_back('{1, 2});
    qa.push_back('{2, 3});
    tick(1);
    hit_a = '0;
    tick(1);
    chk("t2_pulse0", int'(score_pulse_a), 1);
    tick(1);
    chk("t2_pulse1", int'(score_pulse_a), 1);
    tick(1);
    chk("t2_pulse2", int'(score_pulse_a), 1);
    drain_a("t2_drain");
    chk("t2_score", int'(score_a), 3);
    chk("t2_all", int'(all_a), 1);
    chk("t2_state", int'(dut_a.r_state), int'(DONE));
    hit_a = 3'b111;
    tick(3);
    hit_a = '0;
    tick(3);
    chk("t2_done_score", int'(score_a), 3);
    chk("t2_done_pending", int'(pending_a), 0);
    chk("t2_done_all", int'(all_a), 1);

    // held hit scores once
    clear_pulse_a();
    chk("t3_clear_all", int'(all_a), 0);
    hit_a = 3'b001;
    qa.push_back('{0, 1});
    tick(20);
    hit_a = '0;
    tick(3);
    drain_a("t3_drain");
    chk("t3_score", int'(score_a), 1);

    // enable gating before capture
    clear_pulse_a();
    enable_a = 1'b0;
    hit_a = 3'b101;
    tick(3);
    chk("t4_gated_pending", int'(pending_a), 0);
    chk("t4_gated_score", int'(score_a), 0);
    enable_a = 1'b1;
    qa.push_back('{0, 1});
    qa.push_back('{2, 2});
    tick(1);
    hit_a = '0;
    drain_a("t4_drain");
    chk("t4_score", int'(score_a), 2);

    // enable dropped between capture and grant holds pending
    clear_pulse_a();
    hit_a = 3'b011;
    tick(1);
    hit_a = '0;
    enable_a = 1'b0;
    tick(3);
    chk("t4b_held_pending", int'(pending_a), 3);
    chk("t4b_held_score", int'(score_a), 0);
    enable_a = 1'b1;
    qa.push_back('{0, 1});
    qa.push_back('{1, 2});
    drain_a("t4b_drain");
    chk("t4b_score", int'(score_a), 2);

    // Reset in the middle of service
    clear_pulse_a();
    hit_a = 3'b110;
    tick(1);
    hit_a = '0;
    chk("t5_pending_before", int'(pending_a), 6);
    Reset = 1'b1;
    #1;
    chk("t5_rst_pending", int'(pending_a), 0);
    chk("t5_rst_score", int'(score_a), 0);
    tick(1);
    Reset = 1'b0;
    tick(6);
    chk("t5_after_score", int'(score_a), 0);
    chk("t5_after_pending", int'(pending_a), 0);

    // clear in the middle of service
    hit_a = 3'b110;
    tick(1);
    hit_a = '0;
    chk("t6_pending_before", int'(pending_a), 6);
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
    chk("t6_clr_pending", int'(pending_a), 0);
    chk("t6_clr_score", int'(score_a), 0);
    chk("t6_clr_pulse", int'(score_pulse_a), 0);
    tick(5);
    chk("t6_after_score", int'(score_a), 0);

    // eight targets, round-robin wrap across groups
    clear_b = 1'b1;
    tick(1);
    clear_b = 1'b0;
    hit_b = 8'h24;
    qb.push_back('{2, 1});
    qb.push_back('{5, 2});
    tick(1);
    hit_b = '0;
    drain_b("b1_drain");
    hit_b = 8'hC1;
    qb.push_back('{6, 3});
    qb.push_back('{7, 4});
    qb.push_back('{0, 5});
    tick(1);
    hit_b = '0;
    drain_b("b2_drain");
    chk("b2_all", int'(all_b), 0);
    hit_b = 8'h1A;
    qb.push_back('{1, 6});
    qb.push_back('{3, 7});
    qb.push_back('{4, 8});
    tick(1);
    hit_b = '0;
    drain_b("b3_drain");
    tick(2);
    chk("b3_all", int'(all_b), 1);
    chk("b3_score", int'(score_b), 8);

    // BCD carry and saturation
    bc_clear = 1'b1;
    tick(1);
    bc_clear = 1'b0;
    bcd_incs(9);
    chk("bcd_9", int'({bc_tens, bc_ones}), 8'h09);
    bcd_incs(1);
    chk("bcd_10", int'({bc_tens, bc_ones}), 8'h10);
    bcd_incs(89);
    chk("bcd_99", int'({bc_tens, bc_ones}), 8'h99);
    bcd_incs(3);
    chk("bcd_sat", int'({bc_tens, bc_ones}), 8'h99);
    bc_clear = 1'b1;
    bc_inc = 1'b1;
    tick(1);
    bc_clear = 1'b0;
    bc_inc = 1'b0;
    chk("bcd_clear", int'({bc_tens, bc_ones}), 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_arbiter.md
SCORE_ARBITER -- requirements
Module: score_arbiter

Interface
REQ-001 Parameter NUM_TARGETS, default 3, number of scoring requesters (range 2..8).
REQ-002 Parameter ID_W, default 3, width of grant_id; SHALL be at least clog2(NUM_TARGETS).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous game restart, pulsed by game controller in its Start state.
REQ-006 enable  input  1  high while game in Playing state; gates capture and grants.
REQ-007 hit  input  NUM_TARGETS  level request per target, bit i high = target i scored.
REQ-008 grant  output  NUM_TARGETS  registered one-hot grant, one-cycle pulse per served target.
REQ-009 grant_id  output  ID_W  index of granted target, valid while score_pulse high.
REQ-010 score_pulse  output  1  one-cycle pulse coincident with grant.
REQ-011 score  output  11  binary running total.
REQ-012 bcd_ones  output  4  score units digit, BCD.
REQ-013 bcd_tens  output  4  score tens digit, BCD.
REQ-014 pending  output  NUM_TARGETS  captured, not-yet-served requests.
REQ-015 all_scored  output  1  registered flag, every target served this game.

Function
REQ-016 Per-target armed bit SHALL allow each target to score at most once between clears.
REQ-017 Capture: on edge k, pending[i] SHALL set if hit[i] & armed[i] & enable & !pending[i]; armed[i] SHALL clear in the same edge.
REQ-018 Grant: on edge k+1 after capture, if enable and pending nonzero, exactly one target SHALL be granted, chosen round-robin starting at index (last_grant+1) mod NUM_TARGETS.
REQ-019 On a grant edge: pending bit cleared, grant/grant_id/score_pulse asserted for one cycle, score +1, BCD digits +1, last_grant updated.
REQ-020 Latency hit -> score_pulse = 2 edges; simultaneous hits SHALL be served one per cycle with no loss.
REQ-021 A target SHALL NOT be granted twice in consecutive cycles while another target is pending.
REQ-022 enable low: no capture, no grant; pending, armed, score and pointer held.
REQ-023 score SHALL saturate at 2047; BCD SHALL saturate at tens=9, ones=9 (no wrap).
REQ-024 BCD ones 9 -> 0 with tens +1 on increment.
REQ-025 FSM states: IDLE (pending zero), SERVE (pending nonzero), DONE (armed and pending all zero).
REQ-026 Transitions: IDLE->SERVE on capture; SERVE->IDLE when last pending granted and any armed bit remains; SERVE->DONE when last pending granted and armed all zero; any state->IDLE on clear.
REQ-027 all_scored SHALL be high exactly while in DONE; hits in DONE SHALL be ignored.
REQ-028 clear SHALL override capture and grant in the same cycle: pending=0, armed=all ones, score=0, BCD=0, last_grant=NUM_TARGETS-1 (first search starts at 0), outputs deasserted.

Reset
REQ-029 Reset SHALL asynchronously force the REQ-028 clear values, state IDLE, grant=0, grant_id=0, score_pulse=0, all_scored=0.
REQ-030 Reset asserted mid-SERVE SHALL discard all pending requests; no score_pulse after release until a new capture.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, NUM_TARGETS default, BCD digit typedef, and SCORE_MAX=2047.
REQ-032 One sub-module bcd_counter2: two-digit saturating BCD incrementer with sync clear and async Reset.

Verification
REQ-033 Single hit: hit=3'b010 for 1 cycle after clear -> score_pulse 2 edges later, grant_id=1, score=1, bcd=0/1, state IDLE.
REQ-034 Simultaneous: hit=3'b111 one cycle -> grants ids 0,1,2 on three consecutive cycles, score=3, all_scored=1.
REQ-035 Re-hit: hit[0] held high 20 cycles -> exactly one pulse, score=1.
REQ-036 Enable gating: enable=0 with hit=3'b101 -> no pending; raise enable -> ids 0 then 2 served.
REQ-037 BCD: NUM_TARGETS=8, score preloaded by 8 games without clear is illegal, so run with score forced to 9 -> next grant gives ones=0, tens=1; score 99 -> stays 99.
REQ-038 Reset/clear mid-SERVE: pending=3'b110, assert Reset for 1 cycle -> pending=0, score=0, no further pulses; repeat with clear, same result.
